mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 32 +++
 rtl/mem_align.sv | 38 +++
 rtl/mem_access_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller.
//   - Access size encodings (SZ_*) as carried on the Size port
//   - Controller state encoding
//   - Default attached-memory capacity
//   - size_bytes(): number of bytes touched by an access of a given size
package mem_access_ctrl_pkg;

  localparam int unsigned MEM_BYTES_DEF = 1024;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // The reserved size reports 4 so the range check stays well formed;
  // the reserved encoding is rejected separately anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data alignment for the memory access controller.
//   i_size   : access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   i_signed : 1 = sign-extend loads, 0 = zero-extend
//   i_rdata  : little-endian word read from memory at the access address
//   i_wdata  : right-justified store data
//   o_ldata  : load result extended to 32 bits
//   o_mdata  : store word; sub-word stores keep the upper read bytes intact
module mem_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_mdata
);

  always_comb begin
    o_ldata = i_rdata;
    o_mdata = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_ldata = {{24{i_signed & i_rdata[7]}}, i_rdata[7:0]};
        o_mdata = {i_rdata[31:8], i_wdata[7:0]};
      end
      SZ_HALF: begin
        o_ldata = {{16{i_signed & i_rdata[15]}}, i_rdata[15:0]};
        o_mdata = {i_rdata[31:16], i_wdata[15:0]};
      end
      default: begin
        o_ldata = i_rdata;
        o_mdata = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller in front of a byte-addressed,
// little-endian memory with combinational read and posedge write.
//   CLK/RST                : clock, async active-high reset
//   Req/Wr/Size/Signed     : request strobe and attributes (sampled in IDLE)
//   Addr/WData             : byte address, right-justified store data
//   Busy/Done/Fault        : in-flight flag, completion pulse, reject flag
//   RData                  : last successful load result
//   MemRW/MemAddr/MemWData : registered memory write enable / address / data
//   MemRData               : memory read data (four bytes from MemAddr)
// Sub-word stores are read-modify-write because memory writes whole words.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
)(
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [31:0] RData,
  output logic        MemRW,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData
);

  state_e      r_state;
  logic        r_wr;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_memwdata;
  logic        r_fault;

  logic [32:0] w_last;
  logic        w_fault;
  logic [31:0] w_ldata;
  logic [31:0] w_mdata;

  // Last byte touched, computed 33 bits wide so addresses near 2^32
  // cannot wrap around into the legal range.
  always_comb begin
    w_last  = {1'b0, Addr} + {30'd0, size_bytes(Size)} - 33'd1;
    w_fault = (Size == SZ_RSVD)
            | ((Size == SZ_HALF) & Addr[0])
            | ((Size == SZ_WORD) & (|Addr[1:0]))
            | (w_last > (33'(MEM_BYTES) - 33'd1));
  end

  mem_align u_align (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_rdata  (MemRData),
    .i_wdata  (r_wdata),
    .o_ldata  (w_ldata),
    .o_mdata  (w_mdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_wr       <= 1'b0;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_memwdata <= 32'd0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Req) begin
            r_wr     <= Wr;
            r_size   <= Size;
            r_signed <= Signed;
            r_addr   <= Addr;
            r_wdata  <= WData;
            r_fault  <= w_fault;
            if (w_fault) begin
              r_state <= ST_DONE;
            end else if (Wr && (Size == SZ_WORD)) begin
              r_memwdata <= WData;
              r_state    <= ST_WRITE;
            end else begin
              // loads and sub-word stores both need the current word first
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (r_wr) begin
            r_memwdata <= w_mdata;
            r_state    <= ST_WRITE;
          end else begin
            r_rdata <= w_ldata;
            r_state <= ST_DONE;
          end
        end
        ST_WRITE: r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // All memory-side outputs come straight from registers; reset clears
  // r_state asynchronously so MemRW drops the moment RST rises.
  assign Busy     = (r_state != ST_IDLE);
  assign Done     = (r_state == ST_DONE);
  assign Fault    = (r_state == ST_DONE) & r_fault;
  assign MemRW    = (r_state == ST_WRITE);
  assign MemAddr  = r_addr;
  assign MemWData = r_memwdata;
  assign RData    = r_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural byte memory.
module tb_mem_access_ctrl;

  localparam int MEMB = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Req = 1'b0;
  logic        Wr = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        Signed = 1'b0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] WData = 32'd0;
  logic        Busy, Done, Fault, MemRW;
  logic [31:0] RData, MemAddr, MemWData, MemRData;

  mem_access_ctrl #(.MEM_BYTES(MEMB)) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .Wr(Wr), .Size(Size), .Signed(Signed),
    .Addr(Addr), .WData(WData), .Busy(Busy), .Done(Done), .Fault(Fault),
    .RData(RData), .MemRW(MemRW), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData)
  );

  always #5 CLK = ~CLK;

  // memory with 4 guard bytes so a word read at the top stays in range
  logic [7:0] mem [0:MEMB+3];
  int ra;

  always_comb begin
    ra = 0;
    if (MemAddr < 32'(MEMB)) ra = int'(MemAddr);
    MemRData = {mem[ra+3], mem[ra+2], mem[ra+1], mem[ra]};
  end

  always @(posedge CLK) begin
    if (MemRW && (MemAddr < 32'(MEMB))) begin
      for (int k = 0; k < 4; k++) mem[int'(MemAddr)+k] <= MemWData[8*k +: 8];
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int n_wr;
  logic [31:0] wr_addr, wr_data;

  always @(negedge CLK) begin
    if (MemRW) begin
      n_wr++;
      wr_addr = MemAddr;
      wr_data = MemWData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    int          lat;
    logic        fault;
    logic [31:0] rdata;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input int lat, input logic f, input logic [31:0] rd,
                              input int nw, input logic [31:0] wa, input logic [31:0] wd);
    exp_t e;
    e.lat = lat; e.fault = f; e.rdata = rd; e.nwr = nw; e.waddr = wa; e.wdata = wd;
    return e;
  endfunction

  task automatic req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd, input exp_t e);
    exp_t x;
    int   lat;
    logic seen;
    logic f_s;
    logic [31:0] rd_s;
    sb.push_back(e);
    @(negedge CLK);
    n_wr = 0;
    Req = 1'b1; Wr = wr; Size = sz; Signed = sg; Addr = addr; WData = wd;
    @(posedge CLK);
    #1 Req = 1'b0;
    lat = 0; seen = 1'b0; f_s = 1'b0; rd_s = 32'd0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge CLK);
      lat++;
      if (Done) begin
        seen = 1'b1; f_s = Fault; rd_s = RData;
      end
    end
    x = sb.pop_front();
    if (!seen) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_lat"}, 32'(lat), 32'(x.lat));
      chk({tag, "_fault"}, {31'd0, f_s}, {31'd0, x.fault});
      chk({tag, "_rdata"}, rd_s, x.rdata);
    end
    chk({tag, "_nwr"}, 32'(n_wr), 32'(x.nwr));
    if (x.nwr > 0) begin
      chk({tag, "_waddr"}, wr_addr, x.waddr);
      chk({tag, "_wdata"}, wr_data, x.wdata);
    end
  endtask

  function automatic logic [31:0] memw(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    for (int i = 0; i < MEMB + 4; i++) mem[i] = 8'h00;
    mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h83; mem[19] = 8'h44;
    mem[32] = 8'hA1; mem[33] = 8'hA2; mem[34] = 8'hA3; mem[35] = 8'hA4;
    mem[48] = 8'h00; mem[49] = 8'h80; mem[50] = 8'hFF; mem[51] = 8'h7F;

    repeat (3) @(negedge CLK);
    chk("rst_busy",  {31'd0, Busy},  32'd0);
    chk("rst_done",  {31'd0, Done},  32'd0);
    chk("rst_fault", {31'd0, Fault}, 32'd0);
    chk("rst_memrw", {31'd0, MemRW}, 32'd0);
    chk("rst_maddr", MemAddr, 32'd0);
    chk("rst_mwd",   MemWData, 32'd0);
    chk("rst_rdata", RData, 32'd0);
    RST = 1'b0;

    req("ldw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, mk(2, 1'b0, 32'h44832211, 0, 0, 0));
    req("ldbs12", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, mk(2, 1'b0, 32'hFFFFFF83, 0, 0, 0));
    req("ldbu12", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, mk(2, 1'b0, 32'h00000083, 0, 0, 0));
    req("ldhs30", 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, mk(2, 1'b0, 32'hFFFF8000, 0, 0, 0));
    req("ldhu30", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, mk(2, 1'b0, 32'h00008000, 0, 0, 0));
    // word read from 0x11 sees 22 83 44 00, byte lane 0 replaced by AB
    req("stb11",  1'b1, 2'b00, 1'b0, 32'h11, 32'hAB, mk(3, 1'b0, 32'h00008000, 1, 32'h11, 32'h004483AB));
    chk("stb11_mem", memw(16), 32'h4483AB11);
    req("ldw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, mk(2, 1'b0, 32'h4483AB11, 0, 0, 0));
    req("sth12",  1'b1, 2'b01, 1'b0, 32'h12, 32'h12345678, mk(3, 1'b0, 32'h4483AB11, 1, 32'h12, 32'h00005678));
    req("ldw10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, mk(2, 1'b0, 32'h5678AB11, 0, 0, 0));
    req("stw24",  1'b1, 2'b10, 1'b0, 32'h24, 32'hDEADBEEF, mk(2, 1'b0, 32'h5678AB11, 1, 32'h24, 32'hDEADBEEF));
    req("ldw24",  1'b0, 2'b10, 1'b0, 32'h24, 32'h0, mk(2, 1'b0, 32'hDEADBEEF, 0, 0, 0));

    req("f_ldh13",  1'b0, 2'b01, 1'b0, 32'h13, 32'h0, mk(1, 1'b1, 32'hDEADBEEF, 0, 0, 0));
    req("f_stw3fe", 1'b1, 2'b10, 1'b0, 32'h3FE, 32'h1, mk(1, 1'b1, 32'hDEADBEEF, 0, 0, 0));
    req("f_rsvd",   1'b0, 2'b11, 1'b0, 32'h0, 32'h0, mk(1, 1'b1, 32'hDEADBEEF, 0, 0, 0));
    req("f_ldw3fd", 1'b0, 2'b10, 1'b0, 32'h3FD, 32'h0, mk(1, 1'b1, 32'hDEADBEEF, 0, 0, 0));
    req("f_ldw400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, mk(1, 1'b1, 32'hDEADBEEF, 0, 0, 0));
    req("f_ldwtop", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, mk(1, 1'b1, 32'hDEADBEEF, 0, 0, 0));
    req("ldb3ff",   1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, mk(2, 1'b0, 32'h0, 0, 0, 0));
    req("stb3ff",   1'b1, 2'b00, 1'b0, 32'h3FF, 32'hC5, mk(3, 1'b0, 32'h0, 1, 32'h3FF, 32'h000000C5));
    req("ldbs3ff",  1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0, mk(2, 1'b0, 32'hFFFFFFC5, 0, 0, 0));

    // Req held high across a whole load: exactly one completion while busy
    @(negedge CLK);
    Req = 1'b1; Wr = 1'b0; Size = 2'b10; Signed = 1'b0; Addr = 32'h10;
    nd = 0;
    @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (Done) nd++;
      if (i < 2) chk("hold_busy", {31'd0, Busy}, 32'd1);
    end
    Req = 1'b0;
    chk("hold_ndone", 32'(nd), 32'd1);
    chk("hold_idle", {31'd0, Busy}, 32'd0);
    chk("hold_rdata", RData, 32'h5678AB11);

    // reset in the WRITE cycle of a word store to 0x20
    @(negedge CLK);
    n_wr = 0;
    Req = 1'b1; Wr = 1'b1; Size = 2'b10; Addr = 32'h20; WData = 32'h55555555;
    @(posedge CLK);
    @(negedge CLK);
    chk("rstw_memrw_pre", {31'd0, MemRW}, 32'd1);
    RST = 1'b1;
    #1;
    chk("rstw_busy",  {31'd0, Busy},  32'd0);
    chk("rstw_memrw", {31'd0, MemRW}, 32'd0);
    @(negedge CLK);
    RST = 1'b0; Req = 1'b0;
    nd = 0;
    repeat (4) begin
      @(negedge CLK);
      if (Done) nd++;
    end
    chk("rstw_ndone", 32'(nd), 32'd0);
    chk("rstw_mem",   memw(32), 32'hA4A3A2A1);
    chk("rstw_rdata", RData, 32'd0);
    req("ldw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, mk(2, 1'b0, 32'hA4A3A2A1, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
